freq_tone_gen: RTL and testbench
================================

FREQ_TONE_GEN -- requirements
Module: freq_tone_gen

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent tone channels (1..8).
REQ-002 Parameter PRESCALE, default 16: clock cycles per counter tick (1..65535).
REQ-003 Parameter DIV_W, default 8: divider/counter width in bits (8..16); table values are zero-extended to DIV_W.
REQ-004 Parameter CH_W = max(1, clog2(CHANNELS)): derived, not overridden.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  system clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 enable  in  1  when 0, the prescaler and channel counters hold and tone outputs hold.
REQ-009 note_valid  in  1  note load request.
REQ-010 note_ready  out  1  the block can accept a load for note_ch.
REQ-011 note_ch  in  CH_W  target channel; values >= CHANNELS are accepted and discarded.
REQ-012 note_idx  in  4  pitch table address.
REQ-013 note_octave  in  2  octave shift, 0..3.
REQ-014 is_highkey  in  1  selects the high-key pitch table for this load.
REQ-015 tone_out  out  CHANNELS  square wave, one bit per channel.
REQ-016 active  out  CHANNELS  1 = the channel is playing a non-rest note.

Function
REQ-017 The block SHALL contain the team pitch table (decimal).
- Low key, entries 0..13: 51,48,86,43,91,77,38,40,64,32,68,34,57,0.
- High key, entries 0..13: 48,45,81,40,86,72,36,38,61,30,64,32,54,0.
- Entries 14..15: 0 in both tables.
REQ-018 The table value SHALL be looked up and latched at acceptance, together with is_highkey; d_eff = table_value >> note_octave.
REQ-019 d_eff = 0 SHALL mean rest.
REQ-020 Prescaler tick: a free-running counter 0..PRESCALE-1, advancing when enable=1; tick=1 in the cycle it equals PRESCALE-1, after which it wraps to 0. PRESCALE=1 gives tick every enabled cycle.
REQ-021 Per-channel state: div register, counter, tone bit, pending flag, pending div.
REQ-022 Playing channel on tick: if counter == div-1, counter<=0 and tone toggles; otherwise counter increments. Half-period = div ticks.
REQ-023 Resting channel: tone=0, counter=0, active=0.
REQ-024 Handshake: a load is accepted when note_valid & note_ready at a rising edge.
REQ-025 note_ready = !pending[note_ch]; note_ready = 1 for out-of-range note_ch.
REQ-026 Accept into a resting channel: at the next edge div<=d_eff, counter<=0, tone=0; active=1 if d_eff != 0.
REQ-027 Accept into a playing channel: d_eff is stored as pending, and the pending flag is set.
- The pending value is applied at the next counter wrap tick: div<=pending, counter<=0, tone toggles, pending cleared.
- Glitch-free: no half-period is ever truncated.
REQ-028 A pending rest SHALL, at the wrap, force tone=0 and active=0 instead of toggling.
REQ-029 When pending clears at edge N, note_ready for that channel SHALL return to 1 after edge N.
REQ-030 If enable=0 while pending, the pending note SHALL remain held until ticks resume.
REQ-031 Loads SHALL still be accepted when enable=0; resting-channel loads are applied immediately.
REQ-032 Channels SHALL be fully independent; only the prescaler is shared.

Reset
REQ-033 While rst=1, at each edge:
- prescaler, all counters and all div registers <= 0;
- pending cleared, so note_ready=1;
- tone_out=0 and active=0;
- an in-flight load is discarded.
REQ-034 rst SHALL take priority over enable, note_valid and tick in the same cycle.
REQ-035 Reset mid-note SHALL silence all channels at the next edge.

Verification (PRESCALE=1, CHANNELS=2, DIV_W=8)
REQ-036 Reset, then load ch0 idx 9, low key, octave 0 -> active[0]=1 next cycle; tone_out[0] toggles every 32 clocks; ch1 stays 0.
REQ-037 Load ch1 idx 9, high key, octave 1 -> d_eff 15; tone_out[1] half-period 15 clocks; idx 13 or idx 15 -> active=0, tone=0.
REQ-038 While ch0 plays div 32, load idx 0, octave 0 at counter 5 -> note_ready drops next cycle; the current half-period completes at 32; the next half-period is 51; note_ready returns high.
REQ-039 Hold enable=0 for 100 cycles mid-note -> tone and counters frozen; resume -> the remaining half-period is unchanged.
REQ-040 Assert rst with both channels playing and ch0 pending -> next edge: tone_out=00, active=00, note_ready=1; a load on the same cycle as rst is ignored.
REQ-041 Load note_ch=3 (CH_W=1 wraps to a legal value; test with CHANNELS=3, CH_W=2) -> no channel changes; note_ready=1.

Source files
------------

// File: rtl/freq_tone_gen.sv
// Multi-channel square-wave tone generator.
// A shared prescaler produces a tick; each channel divides that tick by a
// per-note divisor taken from the pitch table and shifted by the octave.
// A new note for a sounding channel waits for the end of the current
// half-period, so no half-period is ever cut short.
module freq_tone_gen #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned PRESCALE = 16,
    parameter int unsigned DIV_W    = 8,
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                note_valid,
    output logic                note_ready,
    input  logic [CH_W-1:0]     note_ch,
    input  logic [3:0]          note_idx,
    input  logic [1:0]          note_octave,
    input  logic                is_highkey,
    output logic [CHANNELS-1:0] tone_out,
    output logic [CHANNELS-1:0] active
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    // Pitch table; index 13 and above are rests.
    function automatic logic [6:0] pitch(input logic hk, input logic [3:0] idx);
        logic [6:0] v;
        v = 7'd0;
        if (hk) begin
            case (idx)
                4'd0:  v = 7'd48;
                4'd1:  v = 7'd45;
                4'd2:  v = 7'd81;
                4'd3:  v = 7'd40;
                4'd4:  v = 7'd86;
                4'd5:  v = 7'd72;
                4'd6:  v = 7'd36;
                4'd7:  v = 7'd38;
                4'd8:  v = 7'd61;
                4'd9:  v = 7'd30;
                4'd10: v = 7'd64;
                4'd11: v = 7'd32;
                4'd12: v = 7'd54;
                default: v = 7'd0;
            endcase
        end else begin
            case (idx)
                4'd0:  v = 7'd51;
                4'd1:  v = 7'd48;
                4'd2:  v = 7'd86;
                4'd3:  v = 7'd43;
                4'd4:  v = 7'd91;
                4'd5:  v = 7'd77;
                4'd6:  v = 7'd38;
                4'd7:  v = 7'd40;
                4'd8:  v = 7'd64;
                4'd9:  v = 7'd32;
                4'd10: v = 7'd68;
                4'd11: v = 7'd34;
                4'd12: v = 7'd57;
                default: v = 7'd0;
            endcase
        end
        return v;
    endfunction

    logic [PS_W-1:0]                ps_q;
    logic                           tick;
    logic [CHANNELS-1:0][DIV_W-1:0] div_q;
    logic [CHANNELS-1:0][DIV_W-1:0] cnt_q;
    logic [CHANNELS-1:0][DIV_W-1:0] pend_div_q;
    logic [CHANNELS-1:0]            pend_q;
    logic [CHANNELS-1:0]            tone_q;
    logic [CHANNELS-1:0]            playing;
    logic [CHANNELS-1:0]            ch_sel;
    logic [CHANNELS-1:0]            load;
    logic [DIV_W-1:0]               d_eff;

    assign tick  = enable && (ps_q == PS_LAST);
    assign d_eff = {{(DIV_W-7){1'b0}}, pitch(is_highkey, note_idx)} >> note_octave;

    // Channel decode: an out-of-range note_ch selects nothing, so it is
    // always ready and the load falls on the floor.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        ch_sel  = '0;
        playing = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ch_sel[c]  = (note_ch == CH_W'(c));
            playing[c] = |div_q[c];
        end
    end

    assign note_ready = ~|(ch_sel & pend_q);
    assign load       = {CHANNELS{note_valid}} & ch_sel & ~pend_q;
    assign tone_out   = tone_q;
    assign active     = playing;

    // Shared prescaler: counts 0..PRESCALE-1 while enabled.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst)
            ps_q <= '0;
        else if (enable)
            ps_q <= tick ? '0 : ps_q + 1'b1;
    end

    // Per-channel divider, tone bit and pending-note slot.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (rst) begin
                // NOTE: pend_div is cleared too, though only pend_q gates its use.
                div_q[c]      <= '0;
                cnt_q[c]      <= '0;
                pend_div_q[c] <= '0;
                pend_q[c]     <= 1'b0;
                tone_q[c]     <= 1'b0;
            end else if (load[c] && !playing[c]) begin
                // Resting channel: start the new note at once, even when disabled.
                div_q[c]  <= d_eff;
                cnt_q[c]  <= '0;
                tone_q[c] <= 1'b0;
            end else if (playing[c]) begin
                if (tick) begin
                    if (cnt_q[c] == div_q[c] - DIV_ONE) begin
                        cnt_q[c] <= '0;
                        if (pend_q[c]) begin
                            // Swap notes only on a wrap so the half-period completes.
                            div_q[c]  <= pend_div_q[c];
                            pend_q[c] <= 1'b0;
                            tone_q[c] <= (|pend_div_q[c]) ? ~tone_q[c] : 1'b0;
                        end else begin
                            tone_q[c] <= ~tone_q[c];
                        end
                    end else begin
                        cnt_q[c] <= cnt_q[c] + 1'b1;
                    end
                end
                if (load[c]) begin
                    pend_q[c]     <= 1'b1;
                    pend_div_q[c] <= d_eff;
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_tone_gen.sv
// Self-checking bench for freq_tone_gen with PRESCALE=1, DIV_W=8.
// Instance a: CHANNELS=2.  Instance b: CHANNELS=3 for out-of-range channel loads.
module tb_freq_tone_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;

    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [0:0] a_ch = '0;
    logic [3:0] a_idx = '0;
    logic [1:0] a_oct = '0;
    logic       a_hk = 1'b0;
    logic [1:0] a_tone;
    logic [1:0] a_active;

    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [1:0] b_ch = '0;
    logic [3:0] b_idx = '0;
    logic [1:0] b_oct = '0;
    logic       b_hk = 1'b0;
    logic [2:0] b_tone;
    logic [2:0] b_active;

    int n_pass  = 0;
    int n_total = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    freq_tone_gen #(.CHANNELS(2), .PRESCALE(1), .DIV_W(8)) dut_a (
        .clk(clk), .rst(rst), .enable(enable),
        .note_valid(a_valid), .note_ready(a_ready), .note_ch(a_ch),
        .note_idx(a_idx), .note_octave(a_oct), .is_highkey(a_hk),
        .tone_out(a_tone), .active(a_active)
    );

    freq_tone_gen #(.CHANNELS(3), .PRESCALE(1), .DIV_W(8)) dut_b (
        .clk(clk), .rst(rst), .enable(enable),
        .note_valid(b_valid), .note_ready(b_ready), .note_ch(b_ch),
        .note_idx(b_idx), .note_octave(b_oct), .is_highkey(b_hk),
        .tone_out(b_tone), .active(b_active)
    );

    // One load on instance a, held for exactly one rising edge.
    task automatic load_a(input logic ch, input logic [3:0] idx,
                          input logic [1:0] oct, input logic hk);
        a_ch = ch; a_idx = idx; a_oct = oct; a_hk = hk; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic load_b(input logic [1:0] ch, input logic [3:0] idx,
                          input logic [1:0] oct, input logic hk);
        b_ch = ch; b_idx = idx; b_oct = oct; b_hk = hk; b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    // Edges until instance a's tone bit for ch changes; -1 if budget expires.
    task automatic wait_toggle(input int ch, input int budget, output int cycles);
        logic start;
        bit   done;
        start  = a_tone[ch];
        cycles = -1;
        done   = 1'b0;
        for (int i = 1; i <= budget && !done; i++) begin
            @(negedge clk);
            if (a_tone[ch] !== start) begin
                cycles = i;
                done   = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        if (a_tone !== 2'b00) $display("FAIL reset_tone: got %b expected 00", a_tone); else n_pass++;
        n_total++;
        if (a_active !== 2'b00) $display("FAIL reset_active: got %b expected 00", a_active); else n_pass++;
        n_total++;
        if (a_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", a_ready); else n_pass++;
        n_total++;
        if (b_active !== 3'b000) $display("FAIL reset_b_active: got %b expected 000", b_active); else n_pass++;
        n_total++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ch0, low key idx 9 (32), octave 0: half-period 32 clocks.
    task automatic test_basic;
        int m;
        load_a(1'b0, 4'd9, 2'd0, 1'b0);
        if (a_active !== 2'b01) $display("FAIL basic_active: got %b expected 01", a_active); else n_pass++;
        n_total++;
        repeat (3) exp_q.push_back(32);
        repeat (3) begin
            wait_toggle(0, 40, m);
            if (m !== exp_q[0]) $display("FAIL basic_half_period: got %0d expected %0d", m, exp_q[0]); else n_pass++;
            n_total++;
            void'(exp_q.pop_front());
        end
        if (a_tone[1] !== 1'b0 || a_active[1] !== 1'b0)
            $display("FAIL basic_ch1_idle: got tone %b active %b expected 0 0", a_tone[1], a_active[1]);
        else n_pass++;
        n_total++;
    endtask

    // ch1, high key idx 9 (30) >> 1 = 15; then rest loads.
    task automatic test_ch1;
        int m;
        int polls;
        load_a(1'b1, 4'd9, 2'd1, 1'b1);
        if (a_active !== 2'b11) $display("FAIL ch1_active: got %b expected 11", a_active); else n_pass++;
        n_total++;
        repeat (2) exp_q.push_back(15);
        repeat (2) begin
            wait_toggle(1, 20, m);
            if (m !== exp_q[0]) $display("FAIL ch1_half_period: got %0d expected %0d", m, exp_q[0]); else n_pass++;
            n_total++;
            void'(exp_q.pop_front());
        end
        // Pending rest loaded one edge into a 15-tick half-period: silences 14 edges later.
        load_a(1'b1, 4'd13, 2'd0, 1'b0);
        if (a_ready !== 1'b0) $display("FAIL ch1_pend_ready: got %b expected 0", a_ready); else n_pass++;
        n_total++;
        exp_q.push_back(14);
        polls = -1;
        for (int i = 1; i <= 20 && polls < 0; i++) begin
            @(negedge clk);
            if (a_active[1] === 1'b0) polls = i;
        end
        if (polls !== exp_q[0]) $display("FAIL ch1_rest_delay: got %0d expected %0d", polls, exp_q[0]); else n_pass++;
        n_total++;
        void'(exp_q.pop_front());
        if (a_tone[1] !== 1'b0 || a_ready !== 1'b1)
            $display("FAIL ch1_rest_state: got tone %b ready %b expected 0 1", a_tone[1], a_ready);
        else n_pass++;
        n_total++;
        // Rest (idx 15) into a resting channel keeps it silent.
        load_a(1'b1, 4'd15, 2'd2, 1'b1);
        repeat (3) @(negedge clk);
        if (a_active !== 2'b01 || a_tone[1] !== 1'b0)
            $display("FAIL ch1_idx15: got active %b tone1 %b expected 01 0", a_active, a_tone[1]);
        else n_pass++;
        n_total++;
    endtask

    // Replace a sounding note mid half-period: 32 completes, then 51.
    task automatic test_pending;
        int m;
        wait_toggle(0, 40, m);
        repeat (5) @(negedge clk);
        load_a(1'b0, 4'd0, 2'd0, 1'b0);
        if (a_ready !== 1'b0) $display("FAIL pend_ready_low: got %b expected 0", a_ready); else n_pass++;
        n_total++;
        exp_q.push_back(32);
        exp_q.push_back(51);
        wait_toggle(0, 40, m);
        m = m + 6;
        if (m !== exp_q[0]) $display("FAIL pend_old_half: got %0d expected %0d", m, exp_q[0]); else n_pass++;
        n_total++;
        void'(exp_q.pop_front());
        if (a_ready !== 1'b1) $display("FAIL pend_ready_back: got %b expected 1", a_ready); else n_pass++;
        n_total++;
        wait_toggle(0, 60, m);
        if (m !== exp_q[0]) $display("FAIL pend_new_half: got %0d expected %0d", m, exp_q[0]); else n_pass++;
        n_total++;
        void'(exp_q.pop_front());
    endtask

    // Freeze for 100 cycles 10 ticks into a 51 half-period; loads still accepted.
    task automatic test_enable_hold;
        int m;
        int changes;
        logic [1:0] held;
        repeat (10) @(negedge clk);
        enable = 1'b0;
        held   = a_tone;
        load_a(1'b1, 4'd0, 2'd0, 1'b0);
        if (a_active !== 2'b11 || a_tone[1] !== 1'b0)
            $display("FAIL hold_rest_load: got active %b tone1 %b expected 11 0", a_active, a_tone[1]);
        else n_pass++;
        n_total++;
        load_a(1'b0, 4'd8, 2'd1, 1'b0);
        changes = 0;
        for (int i = 0; i < 98; i++) begin
            @(negedge clk);
            if (a_tone !== held) changes++;
        end
        if (changes !== 0) $display("FAIL hold_frozen: got %0d changed cycles expected 0", changes); else n_pass++;
        n_total++;
        a_ch = 1'b0;
        #1;
        if (a_ready !== 1'b0) $display("FAIL hold_pend_kept: got %b expected 0", a_ready); else n_pass++;
        n_total++;
        enable = 1'b1;
        exp_q.push_back(41);
        exp_q.push_back(32);
        repeat (2) begin
            wait_toggle(0, 60, m);
            if (m !== exp_q[0]) $display("FAIL hold_resume_half: got %0d expected %0d", m, exp_q[0]); else n_pass++;
            n_total++;
            void'(exp_q.pop_front());
        end
    endtask

    // Reset with both channels sounding and ch0 pending; same-cycle load dropped.
    task automatic test_reset_mid;
        load_a(1'b0, 4'd1, 2'd0, 1'b0);
        if (a_ready !== 1'b0) $display("FAIL rmid_pending: got %b expected 0", a_ready); else n_pass++;
        n_total++;
        rst = 1'b1;
        a_ch = 1'b1; a_idx = 4'd9; a_oct = 2'd0; a_hk = 1'b0; a_valid = 1'b1;
        @(negedge clk);
        if (a_tone !== 2'b00 || a_active !== 2'b00)
            $display("FAIL rmid_silence: got tone %b active %b expected 00 00", a_tone, a_active);
        else n_pass++;
        n_total++;
        a_valid = 1'b0;
        rst = 1'b0;
        a_ch = 1'b0;
        #1;
        if (a_ready !== 1'b1) $display("FAIL rmid_ready: got %b expected 1", a_ready); else n_pass++;
        n_total++;
        repeat (3) @(negedge clk);
        if (a_active !== 2'b00 || a_tone !== 2'b00)
            $display("FAIL rmid_load_dropped: got active %b tone %b expected 00 00", a_active, a_tone);
        else n_pass++;
        n_total++;
    endtask

    // CHANNELS=3: note_ch=3 is always ready and changes nothing.
    task automatic test_out_of_range;
        load_b(2'd0, 4'd9, 2'd0, 1'b0);
        if (b_active !== 3'b001) $display("FAIL oor_setup: got %b expected 001", b_active); else n_pass++;
        n_total++;
        b_ch = 2'd3;
        #1;
        if (b_ready !== 1'b1) $display("FAIL oor_ready: got %b expected 1", b_ready); else n_pass++;
        n_total++;
        load_b(2'd3, 4'd0, 2'd0, 1'b0);
        repeat (2) @(negedge clk);
        if (b_active !== 3'b001 || b_tone !== 3'b000)
            $display("FAIL oor_no_change: got active %b tone %b expected 001 000", b_active, b_tone);
        else n_pass++;
        n_total++;
        load_b(2'd2, 4'd9, 2'd1, 1'b1);
        if (b_active !== 3'b101) $display("FAIL oor_ch2_load: got %b expected 101", b_active); else n_pass++;
        n_total++;
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_ch1;
        test_pending;
        test_enable_hold;
        test_reset_mid;
        test_out_of_range;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
